vector_result_writer: RTL and testbench
=======================================

// Module: vector_result_writer
// PURPOSE
//  Write-side sequencer for a vector functional unit's result stream (vector logical, add, shift, ...).
//  On issue, waits the unit's functional latency, then commits one result element per clock.
//  Elements 0..VL-1 go into destination register Vi; mask-generate instructions commit one word to VM instead.
//  Publishes reservation (busy) and an element count for chaining to downstream readers.
// PARAMETERS
//  DATA_W  64  element width
//  VL_W    7   vector-length field width (0..64)
//  MAX_VL  64  elements per V register; larger VL clamps to MAX_VL
//  FU_LAT  2   clocks from accepted start to first valid i_fu_result (>=1)
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous, active-high reset
//  i_start       in   1       issue pulse, one cycle
//  i_i           in   3       destination register number
//  i_vl          in   VL_W    vector length at issue
//  i_to_vm       in   1       1 = mask instruction: result goes to VM, not Vi
//  i_fu_result   in   DATA_W  functional-unit result, one element per clock
//  o_wr_en       out  1       V register write strobe
//  o_wr_reg      out  3       V register select (latched i_i)
//  o_wr_addr     out  6       element address
//  o_wr_data     out  DATA_W  element data
//  o_vm_wr_en    out  1       VM write strobe, one cycle
//  o_vm_data     out  DATA_W  VM data
//  o_chain_cnt   out  VL_W    elements committed so far in the current op
//  o_busy        out  1       Vi/VM reserved
//  o_done        out  1       one-cycle pulse on the final commit
//  o_err         out  1       one-cycle pulse: start rejected while busy
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE. Reset mid-operation aborts with no further writes.
//  Clamp: eff_vl = (i_vl > MAX_VL) ? MAX_VL : i_vl, latched with i_i and i_to_vm at start.
//  FSM: IDLE -> DELAY (start, eff_vl!=0) -> WRITE -> (i_to_vm ? MASK : IDLE); MASK -> IDLE.
//  Zero length: start with eff_vl==0 -> o_done pulses in the cycle after E0; no writes; o_busy stays 0.
//  Timing, start sampled at edge E0:
//  - DELAY holds FU_LAT cycles.
//  - Element n is sampled from i_fu_result at edge E0+FU_LAT+1+n.
//  - Outputs are registered. In the cycle after that edge: o_wr_en=1, o_wr_addr=n, o_wr_data=sample.
//  - o_chain_cnt=n+1 in that same cycle.
//  Vi mode: o_done is high with the last o_wr_en (n=eff_vl-1).
//  Mask mode: o_wr_en stays 0; the FU accumulates the mask itself.
//  - The sample at n=eff_vl-1 drives o_vm_data, with o_vm_wr_en=1 and o_done=1 in the cycle after that edge.
//  o_busy: 1 from the cycle after E0 through the o_done cycle; 0 the cycle after.
//  Start while busy: ignored. o_err=1 for one cycle; the current op is unaffected.
//  Start in the same cycle as o_done: accepted; the new op follows back-to-back.
//  o_chain_cnt clears to 0 on accepted start; it holds its final value until the next start or reset.
//  o_wr_addr counter stops at eff_vl-1 and never wraps; no write beyond MAX_VL-1.
//  o_wr_data/o_vm_data: hold the last value when their strobe is low.
// STRUCTURE
//  Shared package cray_vec_pkg: state enum {IDLE,DELAY,WRITE,MASK}, MAX_VL, VL_W, element address width.
//  Sub-module: vec_elem_counter (load, enable, terminal-count flag); one instance each for the delay and element counts.
// TESTING
//  1. FU_LAT=2, vl=4, i=3, stream A0..A3.
//     Expect writes reg3 addr0..3 = A0..A3 in cycles after E3..E6; o_done with addr3; o_busy low after.
//  2. vl=0, i=5 -> no o_wr_en, no o_vm_wr_en; o_done in the cycle after E0; o_busy never 1.
//  3. i_to_vm=1, vl=3, stream 8000..,C000..,E000.. -> no o_wr_en.
//     Single o_vm_wr_en, o_vm_data=E000.., o_done in the same cycle.
//  4. vl=100 -> exactly 64 writes, last o_wr_addr=63, o_chain_cnt ends at 64.
//  5. Start again at E2 of a vl=4 op -> o_err pulse after E2; first op's 4 writes unchanged.
//  6. rst asserted after the second write of vl=8 -> no further o_wr_en; all outputs 0; next start runs normally.

Source files
------------

// File: rtl/cray_vec_pkg.sv
// Shared types and sizing for the vector result write path.
package cray_vec_pkg;

    localparam int MAX_VL = 64;
    localparam int VL_W   = 7;
    localparam int ADDR_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        WRITE = 2'd2,
        MASK  = 2'd3
    } state_t;

endpackage

// File: rtl/vec_elem_counter.sv
// Loadable down-counter that saturates at zero; terminal count is "counter reads zero".
module vec_elem_counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tc = (cnt_q == '0);

endmodule

// File: rtl/vector_result_writer.sv
// Write-side sequencer for a vector FU result stream: waits the FU latency, then commits
// one element per clock into Vi, or a single mask word into VM.
//   state | meaning
//   IDLE  | no op in flight (also the o_done cycle of a Vi op)
//   DELAY | waiting out the FU latency
//   WRITE | sampling one FU result per clock
//   MASK  | o_done cycle of a mask op; a new start is accepted here
module vector_result_writer
    import cray_vec_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int FU_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [2:0]        i_i,
    input  logic [VL_W-1:0]   i_vl,
    input  logic              i_to_vm,
    input  logic [DATA_W-1:0] i_fu_result,
    output logic              o_wr_en,
    output logic [2:0]        o_wr_reg,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_vm_wr_en,
    output logic [DATA_W-1:0] o_vm_data,
    output logic [VL_W-1:0]   o_chain_cnt,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    state_t state_q, state_d;

    logic [2:0]        reg_q, reg_d;
    logic              to_vm_q, to_vm_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              vm_wr_en_q, vm_wr_en_d;
    logic [DATA_W-1:0] vm_data_q, vm_data_d;
    logic [VL_W-1:0]   chain_cnt_q, chain_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [VL_W-1:0] eff_vl;
    logic            in_flight;
    logic            start_ok;
    logic            dly_tc;
    logic            rem_tc;

    assign eff_vl    = (i_vl > VL_W'(MAX_VL)) ? VL_W'(MAX_VL) : i_vl;
    assign in_flight = (state_q == DELAY) || (state_q == WRITE);
    assign start_ok  = i_start && !in_flight;

    vec_elem_counter #(.W(VL_W)) u_dly_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (start_ok),
        .i_load_val (VL_W'(FU_LAT - 1)),
        .i_en       (state_q == DELAY),
        .o_tc       (dly_tc)
    );

    // Counts remaining elements; terminal count marks the final sample edge.
    vec_elem_counter #(.W(VL_W)) u_rem_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (start_ok),
        .i_load_val (eff_vl - VL_W'(1)),
        .i_en       (state_q == WRITE),
        .o_tc       (rem_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, MASK: state_d = (start_ok && (eff_vl != '0)) ? DELAY : IDLE;
            DELAY:      if (dly_tc) state_d = WRITE;
            WRITE:      if (rem_tc) state_d = to_vm_q ? MASK : IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // chain_cnt_q doubles as the index of the element being sampled this cycle.
    always_comb begin
        reg_d       = reg_q;
        to_vm_d     = to_vm_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        vm_wr_en_d  = 1'b0;
        vm_data_d   = vm_data_q;
        chain_cnt_d = chain_cnt_q;
        done_d      = 1'b0;
        err_d       = i_start && in_flight;
        if (start_ok) begin
            reg_d       = i_i;
            to_vm_d     = i_to_vm;
            chain_cnt_d = '0;
            done_d      = (eff_vl == '0);
        end
        if (state_q == WRITE) begin
            chain_cnt_d = chain_cnt_q + VL_W'(1);
            if (!to_vm_q) begin
                wr_en_d   = 1'b1;
                wr_addr_d = chain_cnt_q[ADDR_W-1:0];
                wr_data_d = i_fu_result;
            end
            if (rem_tc) begin
                done_d = 1'b1;
                if (to_vm_q) begin
                    vm_wr_en_d = 1'b1;
                    vm_data_d  = i_fu_result;
                end
            end
        end
        busy_d = (state_d != IDLE) || (state_q == WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_q       <= '0;
            to_vm_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            vm_wr_en_q  <= 1'b0;
            vm_data_q   <= '0;
            chain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            reg_q       <= reg_d;
            to_vm_q     <= to_vm_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            vm_wr_en_q  <= vm_wr_en_d;
            vm_data_q   <= vm_data_d;
            chain_cnt_q <= chain_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign o_wr_en     = wr_en_q;
    assign o_wr_reg    = reg_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_vm_wr_en  = vm_wr_en_q;
    assign o_vm_data   = vm_data_q;
    assign o_chain_cnt = chain_cnt_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_vector_result_writer.sv
// Bench for vector_result_writer: directed scenarios plus random ops, checked every cycle
// against a schedule-based model (each accepted op books its future output events).
module tb_vector_result_writer;

    localparam int FU_LAT = 2;
    localparam int NE     = 8192;

    logic        clk = 1'b0;
    logic        rst, i_start, i_to_vm;
    logic [2:0]  i_i;
    logic [6:0]  i_vl;
    logic [63:0] i_fu_result;
    logic        o_wr_en, o_vm_wr_en, o_busy, o_done, o_err;
    logic [2:0]  o_wr_reg;
    logic [5:0]  o_wr_addr;
    logic [63:0] o_wr_data, o_vm_data;
    logic [6:0]  o_chain_cnt;

    always #5 clk = ~clk;

    vector_result_writer #(.DATA_W(64), .FU_LAT(FU_LAT)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_i(i_i), .i_vl(i_vl),
        .i_to_vm(i_to_vm), .i_fu_result(i_fu_result),
        .o_wr_en(o_wr_en), .o_wr_reg(o_wr_reg), .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data), .o_vm_wr_en(o_vm_wr_en), .o_vm_data(o_vm_data),
        .o_chain_cnt(o_chain_cnt), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Event schedule indexed by clock edge: what the outputs must show just after that edge.
    bit          s_wr[NE], s_vm[NE], s_done[NE], s_busy[NE], s_err[NE], s_clr[NE], r_hist[NE];
    int          s_elem[NE];
    logic [2:0]  s_reg[NE];
    logic [63:0] fu_hist[NE];

    int e = 0;
    int op_start = -1;
    int op_last  = -1;

    int          x_chain, x_addr;
    logic [2:0]  x_reg;
    logic [63:0] x_wd, x_vd;

    logic [63:0] fu_q[$];
    int obs_wr, obs_vm, obs_busy;

    function automatic void model_edge(int k);
        int eff, first, last;
        fu_hist[k] = i_fu_result;
        if (rst) begin
            r_hist[k] = 1'b1;
            for (int j = k; j < NE; j++) begin
                s_wr[j] = 0; s_vm[j] = 0; s_done[j] = 0; s_busy[j] = 0;
                s_err[j] = 0; s_clr[j] = 0; s_elem[j] = 0;
            end
            op_start = -1;
            op_last  = -1;
            return;
        end
        if (!i_start) return;
        if (k > op_start && k <= op_last) begin
            s_err[k] = 1'b1;
            return;
        end
        eff = (int'(i_vl) > 64) ? 64 : int'(i_vl);
        s_clr[k] = 1'b1;
        s_reg[k] = i_i;
        if (eff == 0) begin
            s_done[k] = 1'b1;
            return;
        end
        first = k + FU_LAT + 1;
        last  = first + eff - 1;
        for (int n = 0; n < eff; n++) begin
            s_elem[first + n] = n + 1;
            s_wr[first + n]   = !i_to_vm;
        end
        for (int j = k; j <= last; j++) s_busy[j] = 1'b1;
        s_done[last] = 1'b1;
        s_vm[last]   = i_to_vm;
        op_start = k;
        op_last  = last;
    endfunction

    task automatic check_edge(int k);
        if (r_hist[k]) begin
            x_chain = 0; x_addr = 0; x_reg = 0; x_wd = 0; x_vd = 0;
        end else begin
            if (s_clr[k]) begin
                x_chain = 0;
                x_reg   = s_reg[k];
            end
            if (s_elem[k] != 0) begin
                x_chain = s_elem[k];
                if (s_wr[k]) begin
                    x_addr = s_elem[k] - 1;
                    x_wd   = fu_hist[k];
                end
                if (s_vm[k]) x_vd = fu_hist[k];
            end
        end
        chk($sformatf("wr_en@%0d", k),    o_wr_en,     s_wr[k]);
        chk($sformatf("wr_reg@%0d", k),   o_wr_reg,    x_reg);
        chk($sformatf("wr_addr@%0d", k),  o_wr_addr,   64'(x_addr));
        chk($sformatf("wr_data@%0d", k),  o_wr_data,   x_wd);
        chk($sformatf("vm_en@%0d", k),    o_vm_wr_en,  s_vm[k]);
        chk($sformatf("vm_data@%0d", k),  o_vm_data,   x_vd);
        chk($sformatf("chain@%0d", k),    o_chain_cnt, 64'(x_chain));
        chk($sformatf("busy@%0d", k),     o_busy,      s_busy[k]);
        chk($sformatf("done@%0d", k),     o_done,      s_done[k]);
        chk($sformatf("err@%0d", k),      o_err,       s_err[k]);
    endtask

    task automatic tick();
        if (e >= NE - 200) begin
            $display("FAIL edge_budget got=%0d exp<%0d", e, NE - 200);
            $fatal(1, "edge budget exhausted");
        end
        i_fu_result = (fu_q.size() != 0) ? fu_q.pop_front() : {$urandom, $urandom};
        @(posedge clk);
        e++;
        model_edge(e);
        #1;
        check_edge(e);
        if (o_wr_en)    obs_wr++;
        if (o_vm_wr_en) obs_vm++;
        if (o_busy)     obs_busy++;
        i_start = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    task automatic issue(input logic [2:0] r, input int vl, input bit m);
        i_start = 1'b1;
        i_i     = r;
        i_vl    = 7'(vl);
        i_to_vm = m;
        tick();
    endtask

    task automatic clr_obs();
        obs_wr = 0; obs_vm = 0; obs_busy = 0;
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_i = '0; i_vl = '0; i_to_vm = 1'b0; i_fu_result = '0;
        clr_obs();
        rst = 1'b1; tick();
        rst = 1'b1; tick();
        chk("reset_busy", o_busy, 0);
        chk("reset_chain", o_chain_cnt, 0);
        idle(2);

        // 1: plain Vi op
        clr_obs();
        issue(3'd3, 4, 1'b0);
        idle(FU_LAT);
        for (int j = 0; j < 4; j++) fu_q.push_back(64'hA0 + 64'(j));
        idle(4);
        chk("t1_last_addr", o_wr_addr, 3);
        chk("t1_last_data", o_wr_data, 64'hA3);
        chk("t1_done", o_done, 1);
        chk("t1_reg", o_wr_reg, 3);
        tick();
        chk("t1_busy_after", o_busy, 0);
        chk("t1_nwr", obs_wr, 4);

        // 2: zero length
        clr_obs();
        issue(3'd5, 0, 1'b0);
        chk("t2_done", o_done, 1);
        idle(4);
        chk("t2_nwr", obs_wr, 0);
        chk("t2_nvm", obs_vm, 0);
        chk("t2_nbusy", obs_busy, 0);

        // 3: mask op
        clr_obs();
        issue(3'd1, 3, 1'b1);
        idle(FU_LAT);
        fu_q.push_back(64'h8000_0000_0000_0000);
        fu_q.push_back(64'hC000_0000_0000_0000);
        fu_q.push_back(64'hE000_0000_0000_0000);
        idle(3);
        chk("t3_vm_en", o_vm_wr_en, 1);
        chk("t3_vm_data", o_vm_data, 64'hE000_0000_0000_0000);
        chk("t3_done", o_done, 1);
        idle(2);
        chk("t3_nwr", obs_wr, 0);
        chk("t3_nvm", obs_vm, 1);

        // 4: clamp
        clr_obs();
        issue(3'd2, 100, 1'b0);
        idle(FU_LAT + 64);
        chk("t4_nwr", obs_wr, 64);
        chk("t4_last_addr", o_wr_addr, 63);
        chk("t4_chain", o_chain_cnt, 64);
        idle(3);
        chk("t4_chain_hold", o_chain_cnt, 64);

        // 5: start rejected while busy
        clr_obs();
        issue(3'd4, 4, 1'b0);
        idle(1);
        issue(3'd6, 9, 1'b1);
        chk("t5_err", o_err, 1);
        idle(FU_LAT + 6);
        chk("t5_nwr", obs_wr, 4);
        chk("t5_reg", o_wr_reg, 4);

        // 6: reset mid-op
        clr_obs();
        issue(3'd7, 8, 1'b0);
        idle(FU_LAT + 2);
        chk("t6_two_writes", obs_wr, 2);
        rst = 1'b1;
        tick();
        chk("t6_wr_en", o_wr_en, 0);
        chk("t6_reg", o_wr_reg, 0);
        clr_obs();
        idle(12);
        chk("t6_no_more", obs_wr, 0);
        issue(3'd0, 3, 1'b0);
        idle(FU_LAT + 4);
        chk("t6_restart", obs_wr, 3);

        // back-to-back: start sampled in the o_done cycle, both modes
        issue(3'd3, 2, 1'b0);
        idle(FU_LAT + 2);
        issue(3'd5, 3, 1'b1);
        chk("b2b_err", o_err, 0);
        idle(FU_LAT + 3);
        issue(3'd6, 2, 1'b0);
        chk("b2b_mask_err", o_err, 0);
        idle(FU_LAT + 4);

        // random ops with random gaps, overlapping starts and occasional resets
        for (int it = 0; it < 60; it++) begin
            int vl, kind;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                rst = 1'b1;
                tick();
            end else begin
                case ($urandom_range(0, 3))
                    0:       vl = 0;
                    1:       vl = int'($urandom_range(60, 127));
                    default: vl = int'($urandom_range(1, 8));
                endcase
                issue(3'($urandom_range(0, 7)), vl, bit'($urandom_range(0, 1)));
                idle(int'($urandom_range(0, FU_LAT + ((vl > 64) ? 64 : vl) + 2)));
            end
        end
        idle(FU_LAT + 70);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
